// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the carry-pipelined adder/subtractor.
package pipelined_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADC = 2'd2
  } op_t;

  // Number of chunk stages needed to cover the full operand width.
  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned chunk_width);
    return width / chunk_width;
  endfunction

  // True when the operand splits into a whole number (>= 1) of chunks.
  function automatic bit chunking_ok(input int unsigned width,
                                     input int unsigned chunk_width);
    return (chunk_width != 0) && (width >= chunk_width) && ((width % chunk_width) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One chunk of the carry pipeline: registered chunk sum, carry out and valid.
module pipelined_adder_stage #(
  parameter int unsigned chunk_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [chunk_width-1:0] a_i,
  input  logic [chunk_width-1:0] b_i,
  input  logic                   cin_i,
  output logic                   valid_o,
  output logic [chunk_width-1:0] sum_o,
  output logic                   cout_o
);

  logic [chunk_width:0]   sum_d;
  logic [chunk_width-1:0] sum_q;
  logic                   cout_q;
  logic                   valid_q;

  // Chunk add with one extra bit to catch the carry out.
  always_comb begin
    sum_d = {1'b0, a_i} + {1'b0, b_i} + (chunk_width + 1)'(cin_i);
  end

  // Stage registers advance only with the global pipeline enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      sum_q   <= sum_d[chunk_width-1:0];
      cout_q  <= sum_d[chunk_width];
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: one chunk per stage, operand skew and
// result de-skew internal, valid/ready on both sides with a single advance.
// Optional signed-overflow output enabled by PIPELINED_ADDER_OVERFLOW_EN.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned width       = 64,
  parameter int unsigned chunk_width = 16,
  parameter int unsigned tag_width   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [width-1:0]     in_lhs,
  input  logic [width-1:0]     in_rhs,
  input  logic                 in_cin,
  input  logic [tag_width-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     out_res,
  output logic                 out_cout,
  output logic [tag_width-1:0] out_tag
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic                 out_ovf
`endif
);

  localparam int unsigned S  = num_stages(width, chunk_width);
  localparam int unsigned CW = chunk_width;

  if (!chunking_ok(width, chunk_width)) begin : g_bad_chunking
    $error("pipelined_adder: width must be a non-zero multiple of chunk_width");
  end
  if (tag_width < 1) begin : g_bad_tag
    $error("pipelined_adder: tag_width must be at least 1");
  end

  op_t              op;
  logic             advance;
  logic [width-1:0] rhs_eff;
  logic             cin0;

  logic [CW-1:0] st_a   [S];
  logic [CW-1:0] st_b   [S];
  logic [CW-1:0] st_sum [S];
  logic          st_cin [S];
  logic          st_cout[S];
  logic          st_vin [S];
  logic          st_vout[S];
  logic [CW-1:0] res_chunk[S];

  logic [tag_width-1:0] tag_q[S];

  assign op       = op_t'(in_op);
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // SUB becomes lhs + ~rhs + 1 so every stage is a plain adder.
  always_comb begin
    rhs_eff = in_rhs;
    cin0    = 1'b0;
    case (op)
      OP_SUB: begin
        rhs_eff = ~in_rhs;
        cin0    = 1'b1;
      end
      OP_ADC:  cin0 = in_cin;
      default: cin0 = 1'b0;
    endcase
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_a[k]   = in_lhs[CW-1:0];
      assign st_b[k]   = rhs_eff[CW-1:0];
      assign st_cin[k] = cin0;
      assign st_vin[k] = in_valid;
    end else begin : g_skew
      localparam int unsigned D = k;
      logic [CW-1:0] a_q[D];
      logic [CW-1:0] b_q[D];

      // Delay chunk k by k stages so it meets the carry from stage k-1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < D; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else if (advance) begin
          a_q[0] <= in_lhs[k*CW +: CW];
          b_q[0] <= rhs_eff[k*CW +: CW];
          for (int unsigned i = 1; i < D; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
        end
      end

      assign st_a[k]   = a_q[D-1];
      assign st_b[k]   = b_q[D-1];
      assign st_cin[k] = st_cout[k-1];
      assign st_vin[k] = st_vout[k-1];
    end

    pipelined_adder_stage #(
      .chunk_width(CW)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (advance),
      .valid_i(st_vin[k]),
      .a_i    (st_a[k]),
      .b_i    (st_b[k]),
      .cin_i  (st_cin[k]),
      .valid_o(st_vout[k]),
      .sum_o  (st_sum[k]),
      .cout_o (st_cout[k])
    );

    if (k == S - 1) begin : g_last
      assign res_chunk[k] = st_sum[k];
    end else begin : g_deskew
      localparam int unsigned D = S - 1 - k;
      logic [CW-1:0] r_q[D];

      // Hold result chunk k until the top chunk of the same operation lands.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < D; i++) begin
            r_q[i] <= '0;
          end
        end else if (advance) begin
          r_q[0] <= st_sum[k];
          for (int unsigned i = 1; i < D; i++) begin
            r_q[i] <= r_q[i-1];
          end
        end
      end

      assign res_chunk[k] = r_q[D-1];
    end
  end

  // Tag rides alongside the operation through all S stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < S; i++) begin
        tag_q[i] <= '0;
      end
    end else if (advance) begin
      tag_q[0] <= in_tag;
      for (int unsigned i = 1; i < S; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Reassemble the aligned result chunks into the output word.
  always_comb begin
    out_res = '0;
    for (int unsigned k = 0; k < S; k++) begin
      out_res[k*CW +: CW] = res_chunk[k];
    end
  end

  assign out_valid = st_vout[S-1];
  assign out_cout  = st_cout[S-1];
  assign out_tag   = tag_q[S-1];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic a_msb_q;
  logic b_msb_q;

  // Sign bits of the top chunk operands are registered with the final stage;
  // carry into the MSB is then a ^ b ^ sum at that bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (advance) begin
      a_msb_q <= st_a[S-1][CW-1];
      b_msb_q <= st_b[S-1][CW-1];
    end
  end

  assign out_ovf = a_msb_q ^ b_msb_q ^ out_res[width-1] ^ out_cout;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (width=32, chunk_width=8, S=4).
module tb_pipelined_adder;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned S  = W / CW;

  typedef struct {
    logic [W-1:0]  res;
    logic          cout;
    logic [TW-1:0] tag;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_lhs;
  logic [W-1:0]  in_rhs;
  logic          in_cin;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic          out_cout;
  logic [TW-1:0] out_tag;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic          out_ovf;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc_cnt  = 0;
  int unsigned n_emit   = 0;

  exp_t        q[$];
  logic [W-1:0] seen_res[$];
  int unsigned  seen_cyc[$];

  pipelined_adder #(
    .width      (W),
    .chunk_width(CW),
    .tag_width  (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_lhs   (in_lhs),
    .in_rhs   (in_rhs),
    .in_cin   (in_cin),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_cout (out_cout),
    .out_tag  (out_tag)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Arithmetic model: unsigned result/carry and signed overflow from plain integers.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] l,
                                 input logic [W-1:0] r, input logic c,
                                 input logic [TW-1:0] t);
    exp_t e;
    longint unsigned ul = {32'd0, l};
    longint unsigned ur = {32'd0, r};
    longint unsigned tot;
    longint sl = longint'($signed(l));
    longint sr = longint'($signed(r));
    longint st;
    case (op)
      2'd1: begin
        tot    = ul - ur;
        e.cout = (ul >= ur);
        st     = sl - sr;
      end
      2'd2: begin
        tot    = ul + ur + {63'd0, c};
        e.cout = tot[32];
        st     = sl + sr + {63'd0, c};
      end
      default: begin
        tot    = ul + ur;
        e.cout = tot[32];
        st     = sl + sr;
      end
    endcase
    e.res = tot[W-1:0];
    e.tag = t;
    e.ovf = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    return e;
  endfunction

  // Compare process: every cycle, outputs against the model queue.
  logic          stalled = 1'b0;
  logic [W-1:0]  held_res;
  logic          held_cout;
  logic [TW-1:0] held_tag;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (stalled) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_res", {32'd0, out_res}, {32'd0, held_res});
        chk("hold_cout", {63'd0, out_cout}, {63'd0, held_cout});
        chk("hold_tag", {60'd0, out_tag}, {60'd0, held_tag});
      end
      if (out_valid) begin
        n_emit++;
        if (q.size() == 0) begin
          chk("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = q[0];
          chk("mdl_res", {32'd0, out_res}, {32'd0, e.res});
          chk("mdl_cout", {63'd0, out_cout}, {63'd0, e.cout});
          chk("mdl_tag", {60'd0, out_tag}, {60'd0, e.tag});
`ifdef PIPELINED_ADDER_OVERFLOW_EN
          chk("mdl_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
`endif
          if (out_ready) begin
            void'(q.pop_front());
            seen_res.push_back(out_res);
            seen_cyc.push_back(cyc_cnt);
          end
        end
      end
      stalled   = out_valid && !out_ready;
      held_res  = out_res;
      held_cout = out_cout;
      held_tag  = out_tag;
      if (in_valid && in_ready) q.push_back(model(in_op, in_lhs, in_rhs, in_cin, in_tag));
    end
  end

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", {32'd0, q.size()}, 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Single op on an empty pipe with literal expectations and latency count.
  task automatic single_op(input string name, input logic [1:0] op,
                           input logic [W-1:0] l, input logic [W-1:0] r,
                           input logic c, input logic [TW-1:0] t,
                           input logic [W-1:0] er, input logic ec, input logic eovf);
    int unsigned lat;
    in_valid = 1'b1; in_op = op; in_lhs = l; in_rhs = r; in_cin = c; in_tag = t;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, {32'd0, lat}, {32'd0, S});
    chk({name, "_res"}, {32'd0, out_res}, {32'd0, er});
    chk({name, "_cout"}, {63'd0, out_cout}, {63'd0, ec});
    chk({name, "_tag"}, {60'd0, out_tag}, {60'd0, t});
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    chk({name, "_ovf"}, {63'd0, out_ovf}, {63'd0, eovf});
`else
    if (eovf === 1'bx) $display("unexpected x in overflow literal");
`endif
    @(posedge clk); #1;
  endtask

  // Present n ADDs (base+i)+(base+i), holding each until accepted; optional stall.
  task automatic stream(input int unsigned n, input int unsigned base,
                        input int unsigned stall_at, input int unsigned stall_len);
    int unsigned i = 0;
    int unsigned c = 0;
    logic acc;
    while (i < n && c < 200) begin
      in_valid = 1'b1; in_op = 2'd0; in_cin = 1'b0;
      in_lhs = W'(base + i); in_rhs = W'(base + i); in_tag = TW'(i);
      out_ready = !(stall_len != 0 && c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      c++;
    end
    chk("stream_sent", {32'd0, i}, {32'd0, n});
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int unsigned emit_before;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_lhs = '0; in_rhs = '0;
    in_cin = 1'b0; in_tag = '0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_res", {32'd0, out_res}, 64'd0);
    chk("rst_cout", {63'd0, out_cout}, 64'd0);
    chk("rst_tag", {60'd0, out_tag}, 64'd0);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    chk("rst_ovf", {63'd0, out_ovf}, 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    single_op("carry_ripple", 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd3, 32'h0000_0000, 1'b1, 1'b0);
    single_op("sub_borrow",   2'd1, 32'd5, 32'd7, 1'b0, 4'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single_op("sub_noborrow", 2'd1, 32'd7, 32'd5, 1'b0, 4'd2, 32'h0000_0002, 1'b1, 1'b0);
    single_op("adc_chain",    2'd2, 32'h0000_FFFF, 32'h0, 1'b1, 4'd4, 32'h0001_0000, 1'b0, 1'b0);
    single_op("add_ign_cin",  2'd0, 32'd1, 32'd1, 1'b1, 4'd5, 32'd2, 1'b0, 1'b0);
    single_op("reserved_add", 2'd3, 32'd1, 32'd2, 1'b1, 4'd6, 32'd3, 1'b0, 1'b0);
    single_op("sub_zero",     2'd1, 32'd0, 32'd0, 1'b0, 4'd7, 32'd0, 1'b1, 1'b0);
    single_op("ovf_pos",      2'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd8, 32'h8000_0000, 1'b0, 1'b1);
    single_op("sub_ovf",      2'd1, 32'h8000_0000, 32'd1, 1'b0, 4'd9, 32'h7FFF_FFFF, 1'b1, 1'b1);
    drain();

    // Back-to-back streaming at full throughput.
    seen_res.delete(); seen_cyc.delete();
    stream(8, 0, 0, 0);
    drain();
    chk("stream_count", {32'd0, seen_res.size()}, 64'd8);
    for (int i = 0; i < 8 && i < seen_res.size(); i++) begin
      chk("stream_res", {32'd0, seen_res[i]}, 64'(2 * i));
      chk("stream_consec", {32'd0, seen_cyc[i] - seen_cyc[0]}, 64'(i));
    end

    // Backpressure: out_ready low for 3 cycles while results are waiting.
    seen_res.delete(); seen_cyc.delete();
    stream(8, 100, 5, 3);
    drain();
    chk("bp_count", {32'd0, seen_res.size()}, 64'd8);
    for (int i = 0; i < 8 && i < seen_res.size(); i++) begin
      chk("bp_res", {32'd0, seen_res[i]}, 64'(2 * (100 + i)));
    end

    // Reset in the middle of a stream discards in-flight operations.
    in_valid = 1'b1; in_op = 2'd0; in_lhs = 32'd10; in_rhs = 32'd20; in_tag = 4'hA;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_res", {32'd0, out_res}, 64'd0);
    chk("midrst_cout", {63'd0, out_cout}, 64'd0);
    chk("midrst_tag", {60'd0, out_tag}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    emit_before = n_emit;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_stale", {32'd0, n_emit - emit_before}, 64'd0);

    // Pipeline still works after the mid-stream reset.
    @(posedge clk); #1;
    single_op("post_rst", 2'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, 4'hC, 32'h2345_6789, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
